uartin: RTL and testbench

//  UART receiver (8N1, LSB first). Pairs with uartout: samples the RX pin, deframes each byte
//  and writes it into a downstream FIFO using the same active-low port/n_cs/n_wr strobe

---
 rtl/uartin_pkg.sv | 31 +++
 rtl/uartin_if.sv | 13 +
 rtl/uartin_sync2.sv | 26 ++
 rtl/uartin.sv | 119 +++++++++++
 tb/tb_uartin.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/uartin_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uartin_pkg;

   // Clock cycles per bit at 115200 baud on a 50 MHz clock; shared with uartout and top.
   localparam int UART_CDIV_115200 = 434;

   // Receiver FSM states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   // Outcome of a stop-bit decision, applied to the strobes one cycle later.
   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_WR   = 2'd1,
      EV_OVR  = 2'd2,
      EV_FERR = 2'd3
   } evt_t;

   // Mid-bit offset used for the start-bit check (floor of half a bit).
   function automatic int half_bit(input int cdiv);
      return cdiv / 2;
   endfunction

endpackage

// File: rtl/uartin_if.sv
// Byte/strobe bus between the UART receiver and its downstream FIFO.
// Latency: n/a (wires only).
// Backpressure: n_cs high means the sink cannot take a byte; the source drops, never stalls.
interface uartin_if;
   logic [7:0] port;    // received byte, held until the next accepted byte
   logic       n_cs;    // sink ready, active low
   logic       n_wr;    // write strobe, active low, one cycle
   logic       n_ferr;  // framing-error pulse, active low, one cycle
   logic       n_ovr;   // overrun pulse, active low, one cycle

   modport master (output port, n_wr, n_ferr, n_ovr, input n_cs);
   modport slave  (input port, n_wr, n_ferr, n_ovr, output n_cs);
endinterface

// File: rtl/uartin_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset to INIT.
// Latency: 2 clk from input change to q.
// Backpressure: none.
module uartin_sync2 #(
   parameter logic INIT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops give the first stage a full cycle to settle.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= INIT;
         q    <= INIT;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uartin.sv
// UART 8N1 receiver: deframes bytes from uart_rx and writes them to a FIFO over bus.
// Latency: n_wr falls 2 + CDIV/2 + 9*CDIV + 1 clk after the first edge seeing the start bit.
// Backpressure: n_cs checked once at mid-stop; if high the byte is dropped and n_ovr pulses.
module uartin
   import uartin_pkg::*;
#(
   parameter int CDIV = UART_CDIV_115200   // clk cycles per bit, must be >= 4
) (
   input  logic     clk,
   input  logic     n_rst,     // synchronous, active high despite the name
   input  logic     uart_rx,
   uartin_if.master bus
);

   localparam int             CW      = $clog2(CDIV);
   localparam logic [CW-1:0]  HALF_M1 = CW'(half_bit(CDIV) - 1);
   localparam logic [CW-1:0]  FULL_M1 = CW'(CDIV - 1);

   logic          rx_s;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_cnt, bit_n;
   logic [7:0]    shreg, shreg_n;
   evt_t          evt, evt_n;

   // The line idles high, so the synchronizer also resets high to avoid a phantom start bit.
   uartin_sync2 #(.INIT(1'b1)) u_sync (
      .clk (clk),
      .rst (n_rst),
      .d   (uart_rx),
      .q   (rx_s)
   );

   // FSM, baud/bit counters, shift register and pending event.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         evt     <= EV_NONE;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_cnt <= bit_n;
         shreg   <= shreg_n;
         evt     <= evt_n;
      end
   end

   // Next-state logic; all line decisions are taken at mid-bit sample points.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      bit_n   = bit_cnt;
      shreg_n = shreg;
      evt_n   = EV_NONE;
      unique case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = ST_START;
         end
         ST_START: begin
            // Re-check half a bit in so a glitch shorter than that is ignored.
            if (cnt == HALF_M1) begin
               cnt_n   = '0;
               bit_n   = '0;
               state_n = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt == FULL_M1) begin
               cnt_n            = '0;
               shreg_n[bit_cnt] = rx_s;
               bit_n            = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = ST_STOP;
            end
         end
         ST_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is caught from IDLE.
            if (cnt == FULL_M1) begin
               cnt_n = '0;
               if (rx_s) begin
                  state_n = ST_IDLE;
                  evt_n   = bus.n_cs ? EV_OVR : EV_WR;
               end else begin
                  state_n = ST_BREAK;
                  evt_n   = EV_FERR;
               end
            end
         end
         ST_BREAK: begin
            // A held-low line must return high before another start can be seen.
            cnt_n = '0;
            if (rx_s) state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Registered strobes and output byte; exactly one strobe per decided frame.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         bus.port   <= 8'h00;
         bus.n_wr   <= 1'b1;
         bus.n_ferr <= 1'b1;
         bus.n_ovr  <= 1'b1;
      end else begin
         bus.n_wr   <= (evt != EV_WR);
         bus.n_ferr <= (evt != EV_FERR);
         bus.n_ovr  <= (evt != EV_OVR);
         if (evt == EV_WR) bus.port <= shreg;
      end
   end

endmodule

// File: tb/tb_uartin.sv
// Directed and random frames into uartin with a strobe scoreboard.
// Latency: n/a.
// Backpressure: n_cs driven by the stimulus sequence.
module tb_uartin;
   import uartin_pkg::*;

   localparam int CDIV   = 8;
   localparam int K_WR   = 1;
   localparam int K_OVR  = 2;
   localparam int K_FERR = 3;

   typedef struct {
      int         kind;
      logic [7:0] port;
   } exp_t;

   logic clk     = 1'b0;
   logic n_rst   = 1'b1;
   logic uart_rx = 1'b1;

   uartin_if bus ();

   int         n_pass     = 0;
   int         n_total    = 0;
   int         cyc        = 0;
   int         last_start = 0;
   exp_t       sb[$];
   int         wr_times[$];
   logic [7:0] last_port  = 8'h00;
   bit         mon_en     = 1'b0;
   exp_t       mon_e;
   int         mon_kind;

   uartin #(.CDIV(CDIV)) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .uart_rx (uart_rx),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push_exp(input int kind, input logic [7:0] b);
      exp_t e;
      e.kind = kind;
      e.port = (kind == K_WR) ? b : last_port;
      if (kind == K_WR) last_port = b;
      sb.push_back(e);
   endtask

   // Each bit is held for exactly CDIV cycles, changed on the falling edge.
   task automatic drive_bits(input logic [9:0] fr, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         uart_rx = fr[i];
         if (i == 0) last_start = cyc + 1;
         repeat (CDIV - 1) @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      drive_bits({stop_v, b, 1'b0}, 10);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk({tag, "_drain"}, sb.size(), 0);
   endtask

   // Scoreboard monitor: every low strobe sample must match the next expected event.
   always @(negedge clk) begin
      if (mon_en && (bus.n_wr !== 1'b1 || bus.n_ferr !== 1'b1 || bus.n_ovr !== 1'b1)) begin
         chk("strobe_excl", 32'((!bus.n_wr) + (!bus.n_ferr) + (!bus.n_ovr)), 1);
         mon_kind = !bus.n_wr ? K_WR : (!bus.n_ovr ? K_OVR : K_FERR);
         if (!bus.n_wr) wr_times.push_back(cyc);
         if (sb.size() == 0) begin
            chk("unexpected_strobe", {29'b0, bus.n_wr, bus.n_ferr, bus.n_ovr}, 32'h7);
         end else begin
            mon_e = sb.pop_front();
            chk("strobe_kind", mon_kind, mon_e.kind);
            if (mon_e.kind != K_FERR) chk("port", bus.port, mon_e.port);
         end
      end
   end

   initial begin
      int lat;
      int b;
      bus.n_cs = 1'b0;

      // Reset
      repeat (4) @(negedge clk);
      n_rst = 1'b0;
      @(negedge clk);
      chk("rst_port", bus.port, 8'h00);
      chk("rst_n_wr", bus.n_wr, 1'b1);
      chk("rst_n_ferr", bus.n_ferr, 1'b1);
      chk("rst_n_ovr", bus.n_ovr, 1'b1);
      chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
      mon_en = 1'b1;
      repeat (5) @(negedge clk);

      // 1: single frame, latency from start edge
      wr_times.delete();
      push_exp(K_WR, 8'h41);
      send_frame(8'h41, 1'b1);
      lat = last_start;
      wait_drain("t1");
      chk("t1_wr_count", wr_times.size(), 1);
      lat = (wr_times.size() > 0) ? (wr_times[0] - lat) : -1;
      chk("t1_latency", lat, 79);

      // 2: false start, then a good frame
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (30) @(negedge clk);
      chk("t2_idle", 32'(dut.state), 32'(ST_IDLE));
      push_exp(K_WR, 8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_drain("t2");

      // 3: framing error with a long break, then recovery
      push_exp(K_FERR, 8'h00);
      send_frame(8'h55, 1'b0);
      repeat (20 * CDIV) @(negedge clk);
      chk("t3_break_hold", 32'(dut.state), 32'(ST_BREAK));
      uart_rx = 1'b1;
      repeat (3 * CDIV) @(negedge clk);
      push_exp(K_WR, 8'h7A);
      send_frame(8'h7A, 1'b1);
      wait_drain("t3");

      // 4: overrun while the sink is full
      bus.n_cs = 1'b1;
      push_exp(K_OVR, 8'h33);
      send_frame(8'h33, 1'b1);
      wait_drain("t4");
      bus.n_cs = 1'b0;
      chk("t4_port_kept", bus.port, 8'h7A);

      // 5: back-to-back frames with no idle gap
      repeat (3 * CDIV) @(negedge clk);
      wr_times.delete();
      push_exp(K_WR, 8'h00);
      push_exp(K_WR, 8'hFF);
      push_exp(K_WR, 8'hA5);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'hA5, 1'b1);
      wait_drain("t5");
      chk("t5_wr_count", wr_times.size(), 3);
      lat = (wr_times.size() >= 3) ? (wr_times[1] - wr_times[0]) : -1;
      chk("t5_gap01", lat, 80);
      lat = (wr_times.size() >= 3) ? (wr_times[2] - wr_times[1]) : -1;
      chk("t5_gap12", lat, 80);

      // 6: reset in the middle of data bit 4, then a clean frame
      repeat (3 * CDIV) @(negedge clk);
      drive_bits({1'b1, 8'hC3, 1'b0}, 5);
      @(negedge clk);
      uart_rx = 1'b0;          // bit 4 of 0xC3
      repeat (3) @(negedge clk);
      n_rst   = 1'b1;
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
      chk("t6_port", bus.port, 8'h00);
      chk("t6_n_wr", bus.n_wr, 1'b1);
      chk("t6_n_ferr", bus.n_ferr, 1'b1);
      chk("t6_n_ovr", bus.n_ovr, 1'b1);
      chk("t6_state", 32'(dut.state), 32'(ST_IDLE));
      n_rst = 1'b0;
      last_port = 8'h00;
      repeat (3 * CDIV) @(negedge clk);
      push_exp(K_WR, 8'h3C);
      send_frame(8'h3C, 1'b1);
      wait_drain("t6");

      // Random bytes with small random idle gaps
      for (int i = 0; i < 256; i++) begin
         b = $urandom_range(0, 255);
         push_exp(K_WR, 8'(b));
         send_frame(8'(b), 1'b1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain("rand");
      chk("final_idle", 32'(dut.state), 32'(ST_IDLE));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
